ps2_key_ctrl: RTL
=================

# ps2_key_ctrl

Controller that sequences reception of PS/2 keyboard frames and arbitrates each decoded key between two uses: recording a reference key and verifying later keys against it. It sits between the raw kbclk/kbdata pins and the 7-segment display and result LEDs. It replaces the unsynchronised clock-gated capture with a single-clock, oversampled receiver. It validates start, parity and stop bits, strips break (F0) and extended (E0) sequences, and drives a record/verify sequencer.

## Interface
- FILT, 4: consecutive identical samples required before the filtered kbclk changes level (range 2–15).
- TIMEOUT_CYC, 5000: clkin cycles without a kbclk falling edge, while mid-frame, before the frame is aborted.

- clkin  in  1  system clock; all logic on its rising edge.
- rst  in  1  reset; synchronous and active-high.
- kbclk  in  1  PS/2 clock pin, asynchronous.
- kbdata  in  1  PS/2 data pin, asynchronous.
- check  in  1  mode: 0 = record, 1 = verify.
- code  out  8  last accepted make code.
- code_vld  out  1  one-cycle pulse when code updates.
- dout  out  8  7-segment pattern of the last accepted make code.
- jgout  out  4  result: 4'b0000 none, 4'b1010 match, 4'b1011 mismatch.
- err  out  1  one-cycle pulse on parity, stop or timeout error.

## Operation
- Input conditioning
  - kbclk and kbdata each pass through a 2-FF synchroniser.
  - The synchronised kbclk feeds a FILT-deep glitch filter; its level changes only after FILT equal samples.
  - A filtered 1→0 transition is a "fall" event.
- Frame FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: a fall with kbdata=0 → DATA, bitcnt=0. A fall with kbdata=1 is ignored.
  - DATA: each fall right-shifts kbdata into sr[7] (LSB first). After the 8th bit → PARITY.
  - PARITY: capture the parity bit → STOP.
  - STOP: on fall, accept the byte if ^{sr, parity}==1 (odd parity) and kbdata==1; otherwise pulse err. Either way → IDLE.
  - Timeout: the counter clears on every fall and counts in non-IDLE states. Reaching TIMEOUT_CYC pulses err and forces IDLE; the partial byte is discarded.
- Byte decoder
  - F0 sets brk; E0 sets ext. Neither emits anything.
  - Any other byte when brk=1 or ext=1: discarded, both flags cleared (releases and extended keys are ignored).
  - Otherwise the byte is a make code: code←byte, code_vld pulses. Typematic repeats emit each time.
- Sequencer, on code_vld
  - check=0: ref←code, ref_vld←1, jgout←0000.
  - check=1: jgout←1010 if ref_vld and code==ref, else 1011.
- A change of check (compared against a registered copy) clears jgout to 0000 when no code_vld occurs that cycle.
- dout is registered and updated on code_vld. Map (hex scancode→pattern): 16→06, 1E→5B, 26→4F, 25→66, 2E→6D, 36→7D, 3D→07, 3E→7F, 46→6F, 45→3F, 1C→77, 32→7C, 21→39, 23→5E, 24→79, 2B→71. Any other code→00.

## Timing
- Reset values: code=00, code_vld=0, dout=00, jgout=0000, err=0. Also FSM=IDLE, brk=ext=0, ref=00, ref_vld=0, filter level=1, timeout counter=0.
- A fall event is seen 2 (sync) + FILT cycles after the pin edge.
- code_vld, code, dout and jgout all update in the cycle after the STOP fall event, simultaneously.
- err pulses in the cycle after the failing STOP fall, or in the cycle after the timeout count is reached.
- check changing in the same cycle as code_vld: the new check value selects record/verify; the result is written and the clear is suppressed.
- rst asserted mid-frame aborts the frame with no err and no code_vld, and also clears ref_vld.
- Maximum frame rate: limited only by FILT (kbclk high/low phases ≥ FILT+1 cycles each).

## Test plan
- Record then verify: check=0, send 16; then check=1, send 16 → code_vld pulses each time, dout=06, jgout=1010.
- Mismatch: with ref=16, check=1, send 1E → jgout=1011, dout=5B, code=1E.
- Break handling: send 1C, F0, 1C → exactly one code_vld (code=1C, dout=77). The F0 and the second 1C produce no pulse.
- Frame errors: a bad-parity frame gives err=1 for one cycle, no code_vld, and outputs unchanged. Stopping kbclk after 5 bits gives err after TIMEOUT_CYC cycles and FSM=IDLE; a following good frame 45 then yields dout=3F.
- Glitch rejection: kbclk low pulses of FILT-1 cycles during IDLE and DATA → no bit sampled, and the frame still decodes correctly.
- Reset and no reference: assert rst mid-frame → all outputs at reset values; then check=1, send 16 → jgout=1011 (ref_vld=0).

Source files
------------

// File: rtl/ps2_key_ctrl_if.sv
// Signal bundle between the PS/2 key controller and whatever drives the pins
// and the mode switch, and reads the display and result outputs.
interface ps2_key_ctrl_if;
  logic       kbclk;     // PS/2 clock pin (asynchronous)
  logic       kbdata;    // PS/2 data pin (asynchronous)
  logic       check;     // 0 = record reference, 1 = verify against it
  logic [7:0] code;      // last accepted make code
  logic       code_vld;  // one-cycle pulse when code updates
  logic [7:0] dout;      // 7-segment pattern of code
  logic [3:0] jgout;     // 0000 none, 1010 match, 1011 mismatch
  logic       err;       // one-cycle pulse on parity/stop/timeout error

  modport master (
    output kbclk, kbdata, check,
    input  code, code_vld, dout, jgout, err
  );

  modport slave (
    input  kbclk, kbdata, check,
    output code, code_vld, dout, jgout, err
  );
endinterface

// File: rtl/ps2_key_ctrl.sv
// PS/2 keyboard receiver with break/extended stripping and a record/verify
// sequencer. Everything runs on clkin; the PS/2 pins are oversampled.
module ps2_key_ctrl #(
  parameter int FILT        = 4,
  parameter int TIMEOUT_CYC = 5000
) (
  input  logic           clkin,
  input  logic           rst,
  ps2_key_ctrl_if.slave  bus
);

  localparam int              TW          = $clog2(TIMEOUT_CYC + 1);
  localparam logic [3:0]      FILT_LAST   = 4'(FILT - 1);
  localparam logic [TW-1:0]   TMO_LAST    = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  logic          r_kbclk_s1, r_kbclk_s2, r_kbdata_s1, r_kbdata_s2;
  logic          r_clk_flt;
  logic [3:0]    r_flt_cnt;
  logic          w_fall;

  state_t        r_state, w_state_next;
  logic [2:0]    r_bitcnt, w_bitcnt_next;
  logic [7:0]    r_sr, w_sr_next;
  logic          r_par, w_par_next;
  logic [TW-1:0] r_tmo, w_tmo_next;
  logic          w_accept, w_frame_err;

  logic          r_brk, r_ext;
  logic          w_is_f0, w_is_e0, w_make;
  logic [7:0]    w_seg;

  logic [7:0]    r_code, r_dout, r_ref;
  logic          r_code_vld, r_ref_vld, r_err, r_check_d;
  logic [3:0]    r_jgout;

  // Two-flop synchronisers for both pins (idle level is high)
  always_ff @(posedge clkin) begin
    if (rst) begin
      r_kbclk_s1  <= 1'b1;
      r_kbclk_s2  <= 1'b1;
      r_kbdata_s1 <= 1'b1;
      r_kbdata_s2 <= 1'b1;
    end else begin
      r_kbclk_s1  <= bus.kbclk;
      r_kbclk_s2  <= r_kbclk_s1;
      r_kbdata_s1 <= bus.kbdata;
      r_kbdata_s2 <= r_kbdata_s1;
    end
  end

  // Glitch filter: level follows kbclk only after FILT consecutive differing samples
  always_ff @(posedge clkin) begin
    if (rst) begin
      r_clk_flt <= 1'b1;
      r_flt_cnt <= '0;
    end else if (r_kbclk_s2 == r_clk_flt) begin
      r_flt_cnt <= '0;
    end else if (r_flt_cnt == FILT_LAST) begin
      r_clk_flt <= r_kbclk_s2;
      r_flt_cnt <= '0;
    end else begin
      r_flt_cnt <= r_flt_cnt + 4'd1;
    end
  end

  // Fall event is the cycle in which the filtered level commits 1 -> 0
  assign w_fall = r_clk_flt & ~r_kbclk_s2 & (r_flt_cnt == FILT_LAST);

  // Frame FSM next-state: start/data/parity/stop sequencing plus inactivity timeout
  always_comb begin
    w_state_next  = r_state;
    w_bitcnt_next = r_bitcnt;
    w_sr_next     = r_sr;
    w_par_next    = r_par;
    w_tmo_next    = (r_state == S_IDLE || w_fall) ? '0 : r_tmo + TW'(1);
    w_accept      = 1'b0;
    w_frame_err   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_fall && !r_kbdata_s2) begin
          w_state_next  = S_DATA;
          w_bitcnt_next = '0;
        end
      end
      S_DATA: begin
        if (w_fall) begin
          w_sr_next = {r_kbdata_s2, r_sr[7:1]};
          if (r_bitcnt == 3'd7) w_state_next = S_PARITY;
          else                  w_bitcnt_next = r_bitcnt + 3'd1;
        end
      end
      S_PARITY: begin
        if (w_fall) begin
          w_par_next   = r_kbdata_s2;
          w_state_next = S_STOP;
        end
      end
      S_STOP: begin
        if (w_fall) begin
          if ((^{r_sr, r_par}) && r_kbdata_s2) w_accept    = 1'b1;
          else                                 w_frame_err = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
    // A stalled frame is abandoned; the partial byte is simply never accepted
    if (r_state != S_IDLE && !w_fall && r_tmo == TMO_LAST) begin
      w_state_next = S_IDLE;
      w_tmo_next   = '0;
      w_frame_err  = 1'b1;
    end
  end

  // Frame FSM state and datapath registers
  always_ff @(posedge clkin) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_bitcnt <= '0;
      r_sr     <= '0;
      r_par    <= 1'b0;
      r_tmo    <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_bitcnt <= w_bitcnt_next;
      r_sr     <= w_sr_next;
      r_par    <= w_par_next;
      r_tmo    <= w_tmo_next;
      r_err    <= w_frame_err;
    end
  end

  assign w_is_f0 = (r_sr == 8'hF0);
  assign w_is_e0 = (r_sr == 8'hE0);
  assign w_make  = w_accept & ~w_is_f0 & ~w_is_e0 & ~r_brk & ~r_ext;

  // Prefix tracking: the byte following F0/E0 is swallowed and clears both flags
  always_ff @(posedge clkin) begin
    if (rst) begin
      r_brk <= 1'b0;
      r_ext <= 1'b0;
    end else if (w_accept) begin
      if (w_is_f0)             r_brk <= 1'b1;
      else if (w_is_e0)        r_ext <= 1'b1;
      else if (r_brk || r_ext) begin
        r_brk <= 1'b0;
        r_ext <= 1'b0;
      end
    end
  end

  // Scancode to 7-segment lookup (hex digits 1..9, 0, A..F)
  always_comb begin
    w_seg = 8'h00;
    case (r_sr)
      8'h16: w_seg = 8'h06;
      8'h1E: w_seg = 8'h5B;
      8'h26: w_seg = 8'h4F;
      8'h25: w_seg = 8'h66;
      8'h2E: w_seg = 8'h6D;
      8'h36: w_seg = 8'h7D;
      8'h3D: w_seg = 8'h07;
      8'h3E: w_seg = 8'h7F;
      8'h46: w_seg = 8'h6F;
      8'h45: w_seg = 8'h3F;
      8'h1C: w_seg = 8'h77;
      8'h32: w_seg = 8'h7C;
      8'h21: w_seg = 8'h39;
      8'h23: w_seg = 8'h5E;
      8'h24: w_seg = 8'h79;
      8'h2B: w_seg = 8'h71;
      default: w_seg = 8'h00;
    endcase
  end

  // Record/verify sequencer; a mode change with no new key clears the result
  always_ff @(posedge clkin) begin
    if (rst) begin
      r_code     <= '0;
      r_code_vld <= 1'b0;
      r_dout     <= '0;
      r_ref      <= '0;
      r_ref_vld  <= 1'b0;
      r_jgout    <= '0;
      r_check_d  <= 1'b0;
    end else begin
      r_check_d  <= bus.check;
      r_code_vld <= w_make;
      if (w_make) begin
        r_code <= r_sr;
        r_dout <= w_seg;
        if (!bus.check) begin
          r_ref     <= r_sr;
          r_ref_vld <= 1'b1;
          r_jgout   <= 4'b0000;
        end else begin
          r_jgout <= (r_ref_vld && r_sr == r_ref) ? 4'b1010 : 4'b1011;
        end
      end else if (bus.check != r_check_d) begin
        r_jgout <= 4'b0000;
      end
    end
  end

  assign bus.code     = r_code;
  assign bus.code_vld = r_code_vld;
  assign bus.dout     = r_dout;
  assign bus.jgout    = r_jgout;
  assign bus.err      = r_err;

endmodule
